// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants, slot state encoding and clog2 helper for the 1-to-N demux
package demux_pkg;

  localparam int DEMUX_WIDTH = 64;
  localparam int DEMUX_N     = 2;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry holding register for a single demux output channel
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  slot_state_t state, state_next;

  always_ff @(posedge clk) begin
    if (rst) state <= SLOT_EMPTY;
    else     state <= state_next;
  end

  // A load while FULL only happens alongside a drain, so load always wins.
  always_comb begin
    state_next = state;
    case (state)
      SLOT_EMPTY: if (load) state_next = SLOT_FULL;
      SLOT_FULL:  if (!load && drain_ready) state_next = SLOT_EMPTY;
      default:    state_next = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)       data <= '0;
    else if (load) data <= load_data;
  end

  assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/demultiplexer_1ton_reg.sv
// rtl/demultiplexer_1ton_reg.sv - registered 1-to-N demux; DEMUX_RR_EN selects round-robin routing
module demultiplexer_1ton_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int N     = DEMUX_N,
  parameter int SEL_W = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]   in_sel,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic               sel_err
);

  localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);

  logic [SEL_W-1:0] sel;
  logic             sel_in_range;
  logic             ready_c;
  logic             accept;
  logic [N-1:0]     load;

  assign sel_in_range = ({1'b0, sel} < N_EXT);

`ifdef DEMUX_RR_EN
  localparam int PTR_W = (clog2(N) < 1) ? 1 : clog2(N);

  logic [PTR_W-1:0] rr_ptr;
  logic             unused_in_sel;

  assign unused_in_sel = ^in_sel;

  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= '0;
    else if (accept)
      rr_ptr <= (rr_ptr == PTR_W'(N-1)) ? '0 : rr_ptr + 1'b1;
  end

  assign sel     = SEL_W'(rr_ptr);
  assign sel_err = 1'b0;
`else
  assign sel = in_sel;

  always_ff @(posedge clk) begin
    if (rst)                          sel_err <= 1'b0;
    else if (accept && !sel_in_range) sel_err <= 1'b1;
  end
`endif

  // Out-of-range words are always taken so they can be dropped without stalling the bus.
  always_comb begin
    ready_c = ~sel_in_range;
    for (int k = 0; k < N; k++) begin
      if (sel == SEL_W'(k) && (!out_valid[k] || out_ready[k])) ready_c = 1'b1;
    end
  end

  assign in_ready = ~rst & ready_c;
  assign accept   = in_valid & in_ready;

  always_comb begin
    load = '0;
    for (int k = 0; k < N; k++) begin
      load[k] = accept && (sel == SEL_W'(k));
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk         (clk),
      .rst         (rst),
      .load        (load[k]),
      .load_data   (in_data),
      .drain_ready (out_ready[k]),
      .valid       (out_valid[k]),
      .data        (out_data[k*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_demultiplexer_1ton_reg.sv
// tb/tb_demultiplexer_1ton_reg.sv - scoreboard bench for the 1-to-N demux (N=2 and N=3 instances)
module tb_demultiplexer_1ton_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         a_in_valid = 1'b0, a_in_ready;
  logic [63:0]  a_in_data  = '0;
  logic         a_in_sel   = 1'b0;
  logic [1:0]   a_out_valid;
  logic [1:0]   a_out_ready = 2'b00;
  logic [127:0] a_out_data;
  logic         a_sel_err;

  logic         b_in_valid = 1'b0, b_in_ready;
  logic [63:0]  b_in_data  = '0;
  logic [1:0]   b_in_sel   = 2'd0;
  logic [2:0]   b_out_valid;
  logic [2:0]   b_out_ready = 3'b000;
  logic [191:0] b_out_data;
  logic         b_sel_err;

  demultiplexer_1ton_reg #(.WIDTH(64), .N(2), .SEL_W(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_sel(a_in_sel), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .sel_err(a_sel_err)
  );

  demultiplexer_1ton_reg #(.WIDTH(64), .N(3), .SEL_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_sel(b_in_sel), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .sel_err(b_sel_err)
  );

  int checks   = 0;
  int failures = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  int          rr_ptr = 0;

  // Scoreboard for dut_a: predicts occupancy and in_ready, pushes on accept, pops on drain.
  always @(negedge clk) begin : monitor
    logic [1:0]  full;
    logic        exp_rdy;
    logic [63:0] exp_d;
    int          s;
    if (rst) begin
      q0.delete();
      q1.delete();
      rr_ptr = 0;
    end else begin
      full = {q1.size() != 0, q0.size() != 0};
      checks++;
      if (a_out_valid !== full) begin
        failures++;
        $display("FAIL sb_out_valid t=%0t actual=%b required=%b", $time, a_out_valid, full);
      end
`ifdef DEMUX_RR_EN
      s = rr_ptr;
`else
      s = int'(a_in_sel);
`endif
      exp_rdy = ~full[s] | a_out_ready[s];
      checks++;
      if (a_in_ready !== exp_rdy) begin
        failures++;
        $display("FAIL sb_in_ready t=%0t actual=%b required=%b", $time, a_in_ready, exp_rdy);
      end
      if (full[0] && a_out_ready[0]) begin
        exp_d = q0.pop_front();
        checks++;
        if (a_out_data[63:0] !== exp_d) begin
          failures++;
          $display("FAIL sb_ch0_data t=%0t actual=%h required=%h", $time, a_out_data[63:0], exp_d);
        end
      end
      if (full[1] && a_out_ready[1]) begin
        exp_d = q1.pop_front();
        checks++;
        if (a_out_data[127:64] !== exp_d) begin
          failures++;
          $display("FAIL sb_ch1_data t=%0t actual=%h required=%h", $time, a_out_data[127:64], exp_d);
        end
      end
      if (a_in_valid && exp_rdy) begin
        if (s == 0) q0.push_back(a_in_data);
        else        q1.push_back(a_in_data);
        rr_ptr = (rr_ptr + 1) % 2;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_in_valid = 1'b1; a_in_data = 64'h1234; a_in_sel = 1'b0;
    b_in_valid = 1'b1; b_in_data = 64'h99;   b_in_sel = 2'd3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (a_in_ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_a_in_ready actual=%b required=0", a_in_ready);
      end
      checks++;
      if (b_in_ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_b_in_ready actual=%b required=0", b_in_ready);
      end
      step();
    end
    rst = 1'b0;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 2'b00 || a_out_data !== 128'd0) begin
      failures++;
      $display("FAIL reset_a_out actual=%b/%h required=00/0", a_out_valid, a_out_data);
    end
    checks++;
    if (a_sel_err !== 1'b0 || b_sel_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_sel_err actual=%b%b required=00", a_sel_err, b_sel_err);
    end
    checks++;
    if (b_out_valid !== 3'b000) begin
      failures++;
      $display("FAIL reset_b_out_valid actual=%b required=000", b_out_valid);
    end
    step();
  endtask

  task automatic test_basic_route();
    a_out_ready = 2'b00;
    a_in_valid = 1'b1; a_in_sel = 1'b1; a_in_data = 64'hDEAD_BEEF_0000_0001;
    step();
    a_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 2'b10) begin
      failures++;
      $display("FAIL basic_out_valid actual=%b required=10", a_out_valid);
    end
    checks++;
    if (a_out_data[127:64] !== 64'hDEAD_BEEF_0000_0001 || a_out_data[63:0] !== 64'd0) begin
      failures++;
      $display("FAIL basic_data actual=%h required=deadbeef00000001_0000000000000000", a_out_data);
    end
    step();
  endtask

  task automatic test_backpressure();
    a_out_ready = 2'b00;
    a_in_valid = 1'b1; a_in_sel = 1'b1; a_in_data = 64'h0BAD;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_in_ready actual=%b required=0", a_in_ready);
    end
    step();
    @(negedge clk);
    checks++;
    if (a_out_data[127:64] !== 64'hDEAD_BEEF_0000_0001) begin
      failures++;
      $display("FAIL bp_data_held actual=%h required=deadbeef00000001", a_out_data[127:64]);
    end
    step();
    a_in_sel = 1'b0; a_in_data = 64'h77;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_other_ready actual=%b required=1", a_in_ready);
    end
    step();
    a_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 2'b11) begin
      failures++;
      $display("FAIL bp_out_valid actual=%b required=11", a_out_valid);
    end
    a_out_ready = 2'b11;
    step();
    a_out_ready = 2'b00;
    step();
  endtask

  task automatic test_drain_load();
    a_out_ready = 2'b00;
    a_in_valid = 1'b1; a_in_sel = 1'b0; a_in_data = 64'h5;
    step();
    a_out_ready = 2'b01; a_in_data = 64'hA;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL dl_in_ready actual=%b required=1", a_in_ready);
    end
    step();
    a_in_valid = 1'b0; a_out_ready = 2'b00;
    @(negedge clk);
    checks++;
    if (a_out_valid[0] !== 1'b1 || a_out_data[63:0] !== 64'hA) begin
      failures++;
      $display("FAIL dl_reload actual=%b/%h required=1/a", a_out_valid[0], a_out_data[63:0]);
    end
    a_out_ready = 2'b01;
    step();
    a_out_ready = 2'b00;
    step();
  endtask

  task automatic test_back_to_back();
    // Channel 1 stalled full; a stream to channel 0 must still flow every cycle.
    a_out_ready = 2'b00;
    a_in_valid = 1'b1; a_in_sel = 1'b1; a_in_data = 64'hC1;
    step();
    a_out_ready = 2'b01;
    for (int i = 0; i < 8; i++) begin
      a_in_sel = 1'b0;
      a_in_data = {$urandom, $urandom};
      @(negedge clk);
      checks++;
      if (a_in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_in_ready i=%0d actual=%b required=1", i, a_in_ready);
      end
      step();
    end
    a_in_valid = 1'b0;
    a_out_ready = 2'b11;
    step();
    a_out_ready = 2'b00;
    step();
  endtask

  task automatic test_bad_sel();
    b_out_ready = 3'b000;
    b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 64'hEE;
    @(negedge clk);
    checks++;
    if (b_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bad_in_ready actual=%b required=1", b_in_ready);
    end
    step();
    b_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (b_out_valid !== 3'b000 || b_sel_err !== 1'b1) begin
      failures++;
      $display("FAIL bad_drop actual=%b/%b required=000/1", b_out_valid, b_sel_err);
    end
    step();
    b_in_valid = 1'b1; b_in_sel = 2'd2; b_in_data = 64'h22;
    step();
    b_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (b_out_valid !== 3'b100 || b_out_data[191:128] !== 64'h22 || b_sel_err !== 1'b1) begin
      failures++;
      $display("FAIL bad_sticky actual=%b/%h/%b required=100/22/1", b_out_valid, b_out_data[191:128], b_sel_err);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (b_sel_err !== 1'b0 || b_out_valid !== 3'b000) begin
      failures++;
      $display("FAIL bad_clear actual=%b/%b required=0/000", b_sel_err, b_out_valid);
    end
    step();
  endtask

  task automatic test_round_robin();
    logic [63:0] got;
    a_out_ready = 2'b11;
    a_in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      a_in_data = 64'(i);
      a_in_sel = 1'($urandom);
      step();
      if (i == 4) a_in_valid = 1'b0;
      @(negedge clk);
      got = ((i % 2) == 1) ? a_out_data[63:0] : a_out_data[127:64];
      checks++;
      if (got !== 64'(i)) begin
        failures++;
        $display("FAIL rr_word%0d actual=%h required=%h", i, got, 64'(i));
      end
    end
    step();
    b_out_ready = 3'b111;
    b_in_valid = 1'b1; b_in_sel = 2'd3;
    for (int i = 0; i < 4; i++) step();
    b_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (b_sel_err !== 1'b0) begin
      failures++;
      $display("FAIL rr_sel_err actual=%b required=0", b_sel_err);
    end
    step();
  endtask

  initial begin
    test_reset();
`ifdef DEMUX_RR_EN
    test_round_robin();
`else
    test_basic_route();
    test_backpressure();
    test_drain_load();
    test_back_to_back();
    test_bad_sel();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
